// File: rtl/spmm_pkg.sv
// Shared constants and types for the SpMM lhs interface.
package spmm_pkg;
    localparam int N     = 16;
    localparam int W     = 8;
    localparam int LGN   = $clog2(N);
    localparam int DBLGN = 2 * $clog2(N);

    typedef struct packed {
        logic [W-1:0] data;
    } data_t;

    typedef enum logic [1:0] {FILL, SEND, DROP, CLEAR} state_t;
endpackage

// File: rtl/nz_compact.sv
// Per-row nonzero detection: mask, rank of each nonzero among lower columns, and total count.
module nz_compact
    import spmm_pkg::*;
(
    input  data_t [N-1:0]        row_data,
    output logic  [N-1:0]        mask,
    output logic  [N-1:0][LGN:0] rank,
    output logic  [LGN:0]        cnt
);
    logic [LGN:0] run;

    // NOTE: blocking '=' is correct in combinational logic: run must update
    // inside the loop, and every output gets a default first so no latch forms.
    always_comb begin
        run  = '0;
        mask = '0;
        rank = '0;
        for (int j = 0; j < N; j++) begin
            mask[j] = |row_data[j].data;
            rank[j] = run;
            run     = run + {{LGN{1'b0}}, mask[j]};
        end
        cnt = run;
    end
endmodule

// File: rtl/csr_lhs_tx.sv
// Compacts a dense N x N lhs matrix, one row per cycle, into one CSR packet for SpMM.
module csr_lhs_tx
    import spmm_pkg::*;
(
    input  logic                         clock,
    input  logic                         reset,
    input  logic                         row_valid,
    output logic                         row_ready,
    input  data_t [N-1:0]                row_data,
    input  logic                         mode_ws,
    input  logic                         mode_os,
    input  logic                         lhs_ready,
    output logic                         lhs_start,
    output logic                         lhs_ws,
    output logic                         lhs_os,
    output logic  [N-1:0][DBLGN-1:0]     lhs_ptr,
    output logic  [N-1:0][LGN-1:0]       lhs_col,
    output data_t [N-1:0]                lhs_data,
    output logic                         ovf_pulse,
    output logic                         ovf_sticky
);
    localparam logic [DBLGN-1:0] N_D   = DBLGN'(N);
    localparam logic [DBLGN-1:0] N1_D  = DBLGN'(N + 1);
    localparam logic [LGN-1:0]   LAST  = LGN'(N - 1);

    state_t                  state;
    logic [LGN-1:0]          row_idx;
    logic [DBLGN-1:0]        base;
    logic                    ovf_flag;

    logic [N-1:0]            mask;
    logic [N-1:0][LGN:0]     rank;
    logic [LGN:0]            cnt;
    logic [DBLGN-1:0]        sum;
    logic [N-1:0][DBLGN-1:0] slot;

    nz_compact u_nz_compact (
        .row_data (row_data),
        .mask     (mask),
        .rank     (rank),
        .cnt      (cnt)
    );

    assign row_ready = (state == FILL);
    assign sum       = base + {{(DBLGN-LGN-1){1'b0}}, cnt};

    // Absolute packet slot each nonzero of the incoming row would land in.
    always_comb begin
        for (int j = 0; j < N; j++)
            slot[j] = base + {{(DBLGN-LGN-1){1'b0}}, rank[j]};
    end

    // NOTE: the packet registers are flops driven straight to the outputs, so
    // they reset with the control state; sequential state uses '<=' only.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state      <= FILL;
            row_idx    <= '0;
            base       <= '0;
            ovf_flag   <= 1'b0;
            lhs_ptr    <= '0;
            lhs_col    <= '0;
            lhs_data   <= '0;
            lhs_start  <= 1'b0;
            lhs_ws     <= 1'b0;
            lhs_os     <= 1'b0;
            ovf_pulse  <= 1'b0;
            ovf_sticky <= 1'b0;
        end else begin
            lhs_start <= 1'b0;
            ovf_pulse <= 1'b0;
            case (state)
                FILL: if (row_valid) begin
                    for (int j = 0; j < N; j++) begin
                        if (mask[j] && slot[j] < N_D) begin
                            lhs_col[slot[j][LGN-1:0]]  <= LGN'(j);
                            lhs_data[slot[j][LGN-1:0]] <= row_data[j];
                        end
                    end
                    lhs_ptr[row_idx] <= (sum > N_D)  ? N_D  : sum;
                    base             <= (sum > N1_D) ? N1_D : sum;
                    if (sum > N_D)
                        ovf_flag <= 1'b1;
                    if (row_idx == '0) begin
                        lhs_ws <= mode_ws;
                        lhs_os <= mode_os;
                    end
                    row_idx <= row_idx + LGN'(1);
                    // The last row's own overflow must count, so test sum, not just the flag.
                    if (row_idx == LAST)
                        state <= (ovf_flag || sum > N_D) ? DROP : SEND;
                end
                SEND: if (lhs_ready) begin
                    lhs_start <= 1'b1;
                    state     <= CLEAR;
                end
                DROP: begin
                    ovf_pulse  <= 1'b1;
                    ovf_sticky <= 1'b1;
                    state      <= CLEAR;
                end
                CLEAR: begin
                    lhs_ptr  <= '0;
                    lhs_col  <= '0;
                    lhs_data <= '0;
                    base     <= '0;
                    row_idx  <= '0;
                    ovf_flag <= 1'b0;
                    state    <= FILL;
                end
                default: state <= FILL;
            endcase
        end
    end
endmodule

// File: doc/csr_lhs_tx.md
Name: csr_lhs_tx

Overview:
- Transmit end of the SpMM lhs interface.
- Accepts a dense N×N left-hand matrix one row per cycle and compacts it into one CSR packet (lhs_ptr / lhs_col / lhs_data, N nonzero slots).
- Drives lhs_start into SpMM when the selected lhs_ready_* is high.
- Sits between the host/matrix source and SpMM; carries the ws/os mode flags with each packet.

Parameters:
- N, 16, matrix dimension and packet slot count.
- W, 8, element data width.
- LGN, $clog2(N), column index width.
- DBLGN, 2*$clog2(N), pointer width.

Ports:
- clock  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low reset (0 = reset)
- row_valid  in  1  row_data holds a valid dense row
- row_ready  out  1  block can accept a row this cycle
- row_data  in  N×data_t  dense row, element j = column j
- mode_ws  in  1  weight-stationary request, sampled with row 0
- mode_os  in  1  output-stationary request, sampled with row 0
- lhs_ready  in  1  SpMM ready for the selected mode (lhs_ready_ns/ws/os/wos muxed outside)
- lhs_start  out  1  one-cycle packet strobe
- lhs_ws  out  1  latched mode_ws, valid while packet held
- lhs_os  out  1  latched mode_os, valid while packet held
- lhs_ptr  out  N×DBLGN  lhs_ptr[i] = number of nonzeros in rows 0..i (exclusive end of row i)
- lhs_col  out  N×LGN  column of slot k
- lhs_data  out  N×data_t  value of slot k
- ovf_pulse  out  1  one-cycle strobe: packet discarded for more than N nonzeros
- ovf_sticky  out  1  set by any overflow, cleared only by reset

Behaviour:
- Reset (reset=0, async):
  - state=FILL, row_idx=0, base=0, ovf_flag=0.
  - All ptr/col/data regs 0; lhs_start=0, lhs_ws=0, lhs_os=0, ovf_pulse=0, ovf_sticky=0.
- All outputs are registered except row_ready, which is decoded from state: row_ready=1 iff state==FILL.
- FILL: row accepted on row_valid && row_ready.
  - Nonzero element j of the row gets rank r (count of nonzeros in columns < j); cnt = total nonzeros in the row.
  - Slot base+r is written with col=j, data=row_data[j], only if base+r < N. Slots ≥ N are dropped.
  - ptr[row_idx] <= min(base+cnt, N); base <= base+cnt, saturating at N+1.
  - If base+cnt > N, set ovf_flag.
  - On row_idx==0, latch mode_ws/mode_os into lhs_ws/lhs_os.
  - Zero elements are never written; unused slots keep col=0, data=0 from the clear.
  - row_idx increments per accepted row. On accepting row N-1:
    - ovf_flag=0 (including the last row's contribution): go to SEND.
    - ovf_flag=1: go to DROP.
- SEND:
  - row_ready=0; ptr/col/data/ws/os held stable.
  - When lhs_ready=1: lhs_start=1 for exactly one cycle, then go to CLEAR.
  - Earliest lhs_start is the cycle after the last row is accepted.
  - lhs_ready=0 holds SEND indefinitely.
- DROP:
  - ovf_pulse=1 for one cycle; ovf_sticky<=1; no lhs_start.
  - Go to CLEAR.
- CLEAR:
  - One cycle: zero all ptr/col/data regs, base=0, row_idx=0, ovf_flag=0.
  - row_ready=0; go to FILL.
  - Packet outputs stay valid through the lhs_start cycle and change only in CLEAR.
- row_valid while not in FILL is ignored; the row is not consumed.
- Gaps in row_valid during FILL are allowed; row_idx holds.
- Throughput: one N-row packet per N+2 cycles when lhs_ready is held high.
- Arithmetic: base/ptr use DBLGN bits. Ranks and cnt use LGN+1 bits (cnt may equal N).

Decomposition:
- spmm_pkg (shared):
  - constants N, W, LGN, DBLGN.
  - data_t packed struct {logic [W-1:0] data}.
  - state enum {FILL, SEND, DROP, CLEAR}.
- One combinational sub-module, nz_compact:
  - Input: row_data.
  - Outputs: per-element nonzero mask, rank[N], cnt.
  - Top level handles slot write, ptr update and the FSM.

Test Plan:
- Identity matrix (row i: col i = 1), lhs_ready=1 -> lhs_start 1 cycle after row 15; ptr[i]=i+1; col[k]=k; data[k]=1; ovf_sticky=0.
- All-zero matrix -> lhs_start fires; ptr all 0; col/data all 0.
- Row 0 all 16 nonzero (value 3), rows 1..15 zero -> ptr all 16; col[k]=k; data[k]=3; no overflow.
- Rows 0 and 1 each 9 nonzeros -> no lhs_start; ovf_pulse one cycle after row 15; ovf_sticky=1; next legal matrix still sends correctly.
- Backpressure: lhs_ready=0 for 5 cycles after row 15 -> row_ready=0, outputs stable; lhs_start in the first cycle lhs_ready=1; mode_ws=1 sampled at row 0 appears on lhs_ws.
- Reset asserted (0) after 7 rows, then released -> row_ready=1, ptr/col/data zero, row_idx=0; full identity matrix afterwards encodes as in the first scenario.
